// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control slice: default pointer width,
// depth and the request/acknowledge FSM encoding.
package fifo_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    NO_OP       = 3'd1,
    WRITE       = 3'd2,
    WR_ERROR    = 3'd3,
    READ        = 3'd4,
    RD_ERROR    = 3'd5,
    RDWR        = 3'd6,
    RD_WR_ERROR = 3'd7
  } state_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer for the FIFO register file; advances by one when enabled
// and rolls over naturally at 2**ADDR_W.
module fifo_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Control stage for the 8 x 32 FIFO: register-file addressing, occupancy
// tracking and per-request acknowledge/error reporting.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   data_count,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(2 ** ADDR_W);

  logic [ADDR_W:0] r_count;
  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == (ADDR_W + 1)'(0));
  // A pop frees the slot a push into a full FIFO needs, so push may ride on it.
  assign w_pop_ok  = rd_en & ~w_empty;
  assign w_push_ok = wr_en & (~w_full | w_pop_ok);

  fifo_ptr #(.ADDR_W(ADDR_W)) u_head (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_push_ok),
    .o_ptr   (wr_addr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_tail (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_pop_ok),
    .o_ptr   (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Both requested: push can only fail when full, and then the pop succeeds.
  always_comb begin
    w_state_nxt = NO_OP;
    case ({wr_en, rd_en})
      2'b00: w_state_nxt = NO_OP;
      2'b10: begin
        if (w_push_ok) begin
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = WR_ERROR;
        end
      end
      2'b01: begin
        if (w_pop_ok) begin
          w_state_nxt = READ;
        end else begin
          w_state_nxt = RD_ERROR;
        end
      end
      2'b11: begin
        if (w_pop_ok) begin
          w_state_nxt = RDWR;
        end else begin
          w_state_nxt = RD_WR_ERROR;
        end
      end
      default: w_state_nxt = NO_OP;
    endcase
  end

  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    case (r_state)
      WRITE:       wr_ack = 1'b1;
      WR_ERROR:    wr_err = 1'b1;
      READ:        rd_ack = 1'b1;
      RD_ERROR:    rd_err = 1'b1;
      RDWR: begin
        wr_ack = 1'b1;
        rd_ack = 1'b1;
      end
      RD_WR_ERROR: begin
        wr_ack = 1'b1;
        rd_err = 1'b1;
      end
      default: begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
      end
    endcase
  end

  assign we         = w_push_ok & ~reset;
  assign full       = w_full;
  assign empty      = w_empty;
  assign data_count = r_count;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a local register file supplies rData, the
// driver queues expected responses and a negedge monitor checks them.
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic        we;
  logic [2:0]  wr_addr;
  logic [2:0]  rd_addr;
  logic        full;
  logic        empty;
  logic [3:0]  data_count;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;

  logic [31:0] wdata;
  logic [31:0] rf [8];
  logic [31:0] rdata;
  logic [31:0] cap_rdata;
  logic        cap_we;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        wack;
    logic        werr;
    logic        rack;
    logic        rerr;
    logic        wrote;
    logic [3:0]  cnt;
    logic [2:0]  wp;
    logic [2:0]  rp;
    logic        full;
    logic        empty;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdq[$];
  int          m_cnt  = 0;
  int          m_head = 0;
  int          m_tail = 0;

  fifo_ctrl #(.ADDR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we         (we),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) rf[wr_addr] <= wdata;
  end
  assign rdata = rf[rd_addr];

  // Pre-edge view of the read port and write enable, for the monitor.
  always @(posedge clk) begin
    cap_rdata <= rdata;
    cap_we    <= we;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wr_ack | wr_err | rd_ack | rd_err) begin
      if (exp_q.size() == 0) begin
        chk("spurious_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err},
            {28'd0, e.wack, e.werr, e.rack, e.rerr});
        chk("we", {31'd0, cap_we}, {31'd0, e.wrote});
        chk("data_count", {28'd0, data_count}, {28'd0, e.cnt});
        chk("wr_addr", {29'd0, wr_addr}, {29'd0, e.wp});
        chk("rd_addr", {29'd0, rd_addr}, {29'd0, e.rp});
        chk("full_empty", {30'd0, full, empty}, {30'd0, e.full, e.empty});
        if (e.rack) chk("rdata", cap_rdata, e.data);
      end
    end
  end

  task automatic op(input logic w, input logic r, input logic [31:0] d);
    exp_t e;
    logic push_ok;
    logic pop_ok;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    wdata = d;
    pop_ok  = r && (m_cnt != 0);
    push_ok = w && ((m_cnt != 8) || pop_ok);
    e = '0;
    if (pop_ok) begin
      e.data = mdq.pop_front();
      m_tail = (m_tail + 1) % 8;
      m_cnt--;
    end
    if (push_ok) begin
      mdq.push_back(d);
      m_head = (m_head + 1) % 8;
      m_cnt++;
    end
    e.wack  = push_ok;
    e.werr  = w && !push_ok;
    e.rack  = pop_ok;
    e.rerr  = r && !pop_ok;
    e.wrote = push_ok;
    e.cnt   = 4'(m_cnt);
    e.wp    = 3'(m_head);
    e.rp    = 3'(m_tail);
    e.full  = (m_cnt == 8);
    e.empty = (m_cnt == 0);
    if (w || r) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, 32'd0);
  endtask

  task automatic rst(input logic w, input int n);
    @(negedge clk);
    reset = 1'b1;
    wr_en = w;
    rd_en = 1'b0;
    wdata = 32'hDEAD_BEEF;
    #1 chk("we_during_reset", {31'd0, we}, 32'd0);
    repeat (n) @(negedge clk);
    chk("reset_count", {28'd0, data_count}, 32'd0);
    chk("reset_ptrs", {26'd0, wr_addr, rd_addr}, 32'd0);
    chk("reset_status", {30'd0, full, empty}, 32'd1);
    chk("reset_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
    reset = 1'b0;
    wr_en = 1'b0;
    mdq.delete();
    m_cnt  = 0;
    m_head = 0;
    m_tail = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = 32'd0;

    // Reset then idle
    rst(1'b0, 2);
    idle(3);
    @(negedge clk);
    chk("idle_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
    chk("idle_status", {26'd0, data_count, full, empty}, 32'd1);

    // Fill with 0x11..0x88 then overflow
    for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 32'h11 * i);
    op(1'b1, 1'b0, 32'h99);

    // Drain and underflow
    for (int i = 0; i < 9; i++) op(1'b0, 1'b1, 32'd0);

    // Simultaneous push+pop at count 3, at full, and at empty
    for (int i = 1; i <= 3; i++) op(1'b1, 1'b0, 32'hA0 + i);
    op(1'b1, 1'b1, 32'hB1);
    for (int i = 1; i <= 5; i++) op(1'b1, 1'b0, 32'hC0 + i);
    op(1'b1, 1'b1, 32'hD1);
    for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 32'd0);
    op(1'b1, 1'b1, 32'hE1);
    op(1'b0, 1'b1, 32'd0);

    // Wrap-around from a clean reset
    rst(1'b0, 1);
    for (int i = 1; i <= 5; i++) op(1'b1, 1'b0, 32'h100 + i);
    for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 32'd0);
    for (int i = 1; i <= 6; i++) op(1'b1, 1'b0, 32'h200 + i);
    op(1'b0, 1'b1, 32'd0);
    op(1'b0, 1'b1, 32'd0);

    // Reset mid-stream with a push request present
    rst(1'b1, 1);
    idle(2);
    @(negedge clk);
    chk("post_reset_empty", {31'd0, empty}, 32'd1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
